// File: rtl/storage_loader.sv
// storage_loader: deserialises MSB-first serial bytes and writes WORDS of them
// into consecutive addresses of a 4x8 storage block. One byte is written per
// WRITE cycle, and a one-cycle done pulse follows the last write.
// Optional feature: define PARITY_CHK_EN to expect a 9th even-parity bit
// after every byte. In that build a bad byte is dropped and the sticky err
// output is set.
`timescale 1ns/1ps

module storage_loader #(
  parameter int WORDS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       sdi,
  input  logic       sdi_en,
`ifdef PARITY_CHK_EN
  output logic       err,
`endif
  output logic       wr,
  output logic [1:0] addr,
  output logic [7:0] d,
  output logic       busy,
  output logic       done
);

  // Word index of the final write in a sequence.
  localparam logic [2:0] LAST_WORD = 3'(WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
`ifdef PARITY_CHK_EN
    S_PARITY,
`endif
    S_WRITE,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [2:0]  word_cnt_q, word_cnt_d;
  logic [1:0]  addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  shift_in;
`ifdef PARITY_CHK_EN
  logic        err_q, err_d;
`endif

  // State register and datapath flops; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (!rst) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      shift_q    <= '0;
`ifdef PARITY_CHK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      shift_q    <= shift_d;
`ifdef PARITY_CHK_EN
      err_q      <= err_d;
`endif
    end
  end

  // Next-state and datapath update for the load sequence.
  always_comb begin
    // NOTE: every target gets a hold default first so no path can infer a latch.
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    shift_d    = shift_q;
`ifdef PARITY_CHK_EN
    err_d      = err_q;
`endif
    // The shift register is 8 bits wide, so the oldest bit falls off the top.
    shift_in   = 8'({shift_q, sdi});

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_SHIFT;
          bit_cnt_d  = '0;
          word_cnt_d = '0;
          addr_d     = '0;
          shift_d    = '0;
        end
      end

      S_SHIFT: begin
        if (sdi_en) begin
          shift_d   = shift_in;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
`ifdef PARITY_CHK_EN
            state_d = S_PARITY;
`else
            state_d = S_WRITE;
            data_d  = shift_in;
`endif
          end
        end
      end

`ifdef PARITY_CHK_EN
      // Even parity: the byte and its parity bit must XOR to zero.
      S_PARITY: begin
        if (sdi_en) begin
          bit_cnt_d = '0;
          if ((^shift_q ^ sdi) == 1'b0) begin
            state_d = S_WRITE;
            data_d  = shift_q;
          end else begin
            err_d   = 1'b1;
            state_d = S_SHIFT;
            shift_d = '0;
          end
        end
      end
`endif

      S_WRITE: begin
        addr_d     = addr_q + 2'd1;
        word_cnt_d = word_cnt_q + 3'd1;
        bit_cnt_d  = '0;
        state_d    = (word_cnt_q == LAST_WORD) ? S_DONE : S_SHIFT;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode: the strobes come from the registered state, and the data
  // outputs come straight from flops.
  always_comb begin
    wr   = (state_q == S_WRITE);
    busy = (state_q != S_IDLE);
    done = (state_q == S_DONE);
    addr = addr_q;
    d    = data_q;
`ifdef PARITY_CHK_EN
    err  = err_q;
`endif
  end

endmodule

// File: tb/tb_storage_loader.sv
// Directed bench for storage_loader. It runs two instances on one shared
// stimulus stream: u_dut1 with WORDS=4 and u_dut2 with WORDS=2. Write strobes
// are logged at each falling edge, and the log is compared with hand-computed
// addresses, data and cycle positions.
`timescale 1ns/1ps

module tb_storage_loader;

`ifdef PARITY_CHK_EN
  localparam int NBITS = 9;
`else
  localparam int NBITS = 8;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       sdi = 1'b0;
  logic       sdi_en = 1'b0;
  logic       wr1, busy1, done1, wr2, busy2, done2;
  logic [1:0] addr1, addr2;
  logic [7:0] d1, d2;
`ifdef PARITY_CHK_EN
  logic       err1, err2;
`endif

  storage_loader #(.WORDS(4)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .sdi(sdi), .sdi_en(sdi_en),
`ifdef PARITY_CHK_EN
    .err(err1),
`endif
    .wr(wr1), .addr(addr1), .d(d1), .busy(busy1), .done(done1)
  );

  storage_loader #(.WORDS(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .sdi(sdi), .sdi_en(sdi_en),
`ifdef PARITY_CHK_EN
    .err(err2),
`endif
    .wr(wr2), .addr(addr2), .d(d2), .busy(busy2), .done(done2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0] addr;
    logic [7:0] d;
    int         cyc;
  } wr_t;

  wr_t log1[$];
  wr_t log2[$];
  int  done1_cyc = -1;
  int  last_strobe = 0;
  int  n_cmp = 0;
  int  n_err = 0;

  // Log every write strobe and the done pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (wr1 === 1'b1) log1.push_back('{addr1, d1, cyc});
    if (wr2 === 1'b1) log2.push_back('{addr2, d2, cyc});
    if (done1 === 1'b1) done1_cyc = cyc;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_wr(input int which, input int idx, input logic [1:0] a, input logic [7:0] dv);
    int  n;
    wr_t e;
    n = (which == 1) ? log1.size() : log2.size();
    if (idx < n) begin
      e = (which == 1) ? log1[idx] : log2[idx];
      check($sformatf("dut%0d_wr%0d_addr", which, idx), 32'(e.addr), 32'(a));
      check($sformatf("dut%0d_wr%0d_d", which, idx), 32'(e.d), 32'(dv));
    end else begin
      check($sformatf("dut%0d_wr%0d_present", which, idx), 32'(n), 32'(idx + 1));
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Serialise one byte MSB first. Idle cycles of length gap go between
  // strobes, and the parity bit is appended when that build is selected.
  task automatic send_byte(input logic [7:0] b, input int gap, input bit bad_par);
    for (int i = 0; i < NBITS; i++) begin
      sdi         = (i < 8) ? b[7 - i] : ((^b) ^ bad_par);
      sdi_en      = 1'b1;
      last_strobe = cyc;
      tick();
      sdi_en      = 1'b0;
      if (i != NBITS - 1) repeat (gap) tick();
    end
  endtask

  // One cycle while the DUT sits in WRITE or DONE, optionally with junk strobes.
  task automatic write_gap(input bit junk, input bit st);
    sdi    = 1'b1;
    sdi_en = junk;
    start  = st;
    tick();
    sdi_en = 1'b0;
    start  = 1'b0;
  endtask

  initial begin
    logic [7:0] part;
    int         last_wr_cyc;

    // Held in reset while start and sdi_en toggle: all outputs stay at zero.
    for (int i = 0; i < 6; i++) begin
      start  = 1'b1;
      sdi_en = (i % 2 == 1);
      sdi    = (i % 3 == 0);
      tick();
      check($sformatf("rst_outs1_%0d", i), 32'({wr1, addr1, d1, busy1, done1}), 0);
      check($sformatf("rst_outs2_%0d", i), 32'({wr2, addr2, d2, busy2, done2}), 0);
    end
    start  = 1'b0;
    sdi_en = 1'b0;
    rst    = 1'b1;

    // The first start after reset is honoured on the first rising edge.
    do_start();
    check("busy_after_start", 32'(busy1), 1);

    // Four bytes with junk strobes in every WRITE cycle. start is also pulsed
    // during the first WRITE, where both instances are busy.
    send_byte(8'h01, 0, 1'b0);
    write_gap(1'b1, 1'b1);
    send_byte(8'hA5, 0, 1'b0);
    write_gap(1'b1, 1'b0);
    send_byte(8'h3C, 0, 1'b0);
    write_gap(1'b1, 1'b0);
    send_byte(8'hFF, 0, 1'b0);
    check("wr_4th", 32'(wr1), 1);
    write_gap(1'b1, 1'b0);
    check("done_pulse", 32'(done1), 1);
    check("busy_in_done", 32'(busy1), 1);
    sdi_en = 1'b1;
    tick();
    sdi_en = 1'b0;
    check("busy_after_done", 32'(busy1), 0);
    check("done_cleared", 32'(done1), 0);
    check("addr_wrap_3_to_0", 32'(addr1), 0);
    check("d_holds_last", 32'(d1), 'hFF);
    check("wr_count_run1", 32'(log1.size()), 4);
    expect_wr(1, 0, 2'd0, 8'h01);
    expect_wr(1, 1, 2'd1, 8'hA5);
    expect_wr(1, 2, 2'd2, 8'h3C);
    expect_wr(1, 3, 2'd3, 8'hFF);
    last_wr_cyc = (log1.size() > 0) ? log1[log1.size() - 1].cyc : -100;
    check("done_one_after_wr", 32'(done1_cyc - last_wr_cyc), 1);
    check("w2_wr_count_run1", 32'(log2.size()), 2);
    expect_wr(2, 0, 2'd0, 8'h01);
    expect_wr(2, 1, 2'd1, 8'hA5);

    // A new start restarts at address 0, including in the WORDS=2 instance.
    log1.delete();
    log2.delete();
    do_start();
    send_byte(8'h42, 0, 1'b0);
    write_gap(1'b0, 1'b0);
    send_byte(8'h99, 0, 1'b0);
    write_gap(1'b0, 1'b0);
    check("w2_done_run2", 32'(done2), 1);
    expect_wr(1, 0, 2'd0, 8'h42);
    expect_wr(1, 1, 2'd1, 8'h99);
    expect_wr(2, 0, 2'd0, 8'h42);
    expect_wr(2, 1, 2'd1, 8'h99);
    check("w2_wr_count_run2", 32'(log2.size()), 2);

    // Asynchronous reset mid-sequence clears the outputs without waiting for an edge.
    rst = 1'b0;
    #1;
    check("async_rst_outs", 32'({wr1, addr1, d1, busy1, done1}), 0);
    tick();
    rst = 1'b1;

    // Gapped strobes (one bit every three cycles) for 0x5A.
    log1.delete();
    do_start();
    send_byte(8'h5A, 2, 1'b0);
    write_gap(1'b0, 1'b0);
    check("gap_wr_count", 32'(log1.size()), 1);
    expect_wr(1, 0, 2'd0, 8'h5A);
    check("gap_wr_latency", 32'((log1.size() > 0) ? log1[0].cyc - last_strobe : -1), 1);

    // Five bits of the second byte, then reset: no further writes.
    part = 8'hC3;
    for (int i = 0; i < 5; i++) begin
      sdi    = part[7 - i];
      sdi_en = 1'b1;
      tick();
    end
    sdi_en = 1'b0;
    rst    = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      sdi_en = (i % 2 == 0);
      sdi    = 1'b1;
      tick();
    end
    sdi_en = 1'b0;
    check("no_wr_after_abort", 32'(log1.size()), 1);
    check("idle_after_abort", 32'(busy1), 0);

    // A fresh start after the abort writes 0x77 at address 0.
    do_start();
    send_byte(8'h77, 0, 1'b0);
    expect_wr(1, 1, 2'd0, 8'h77);

    // Reset asserted during WRITE drops wr immediately, and no further writes follow.
    rst = 1'b0;
    #1;
    check("rst_in_write_wr", 32'(wr1), 0);
    tick();
    rst = 1'b1;
    repeat (12) tick();
    check("no_wr_after_write_rst", 32'(log1.size()), 2);

`ifdef PARITY_CHK_EN
    // A bad parity bit sets the sticky err and skips the write; the next
    // good byte still lands at address 0.
    log1.delete();
    do_start();
    send_byte(8'h03, 0, 1'b1);
    check("par_err_set", 32'(err1), 1);
    check("par_no_wr", 32'(log1.size()), 0);
    send_byte(8'h03, 0, 1'b0);
    expect_wr(1, 0, 2'd0, 8'h03);
    check("par_err_sticky", 32'(err1), 1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("par_err_cleared", 32'(err1), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
